// File: rtl/scaler_readout.sv
// scaler_readout: periodic/manual refresh of a scaler bank, sequential capture
// into a capture buffer, host-controlled latch into a read buffer, and a
// one-cycle-latency random-access read port.
//
// Handshake: refresh_o is a one-cycle pulse to the bank; manual_refresh_i and
// latch_i are one-cycle request pulses that are never dropped (held pending if
// they cannot be served at once); every rd_en_i cycle yields exactly one
// rd_valid_o cycle on the following clock, with no backpressure.
//
// Optional feature: define SCALER_READOUT_TIMESTAMP_EN to add a 32-bit count of
// completed captures, snapshotted into refresh_cnt_o on each latch.
module scaler_readout #(
  parameter int NUM_SCALERS = 16,
  parameter int WIDTH       = 12,
  parameter int ADDR_W      = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [31:0]                  period_i,
  input  logic                         manual_refresh_i,
  input  logic [NUM_SCALERS*WIDTH-1:0] scalers_i,
  output logic                         refresh_o,
  input  logic                         latch_i,
  input  logic                         rd_en_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         rd_valid_o,
  output logic                         busy_o,
  output logic                         new_data_o
`ifdef SCALER_READOUT_TIMESTAMP_EN
  ,output logic [31:0]                 refresh_cnt_o
`endif
);

  localparam int IDX_W = (NUM_SCALERS > 1) ? $clog2(NUM_SCALERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SCALERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REFRESH,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // period counter
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        prd_seen_q, prd_seen_d;
  logic        prd_chg;
  logic        auto_req;

  // sequencer
  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic             latch_pend_q, latch_pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             new_data_q, new_data_d;
  logic             refresh_q, refresh_d;
  logic             busy_q, busy_d;
  logic             req;
  logic             do_latch;

  // buffers and read port
  logic [WIDTH-1:0] cap_buf_q [NUM_SCALERS];
  logic [WIDTH-1:0] cap_buf_d [NUM_SCALERS];
  logic [WIDTH-1:0] rd_buf_q  [NUM_SCALERS];
  logic [WIDTH-1:0] rd_buf_d  [NUM_SCALERS];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Period counter next state: counts 0..period-1, restarts when period changes.
  // prd_seen_q suppresses change detection on the first cycle after reset, so the
  // first auto-request lands exactly period_i cycles after release.
  always_comb begin
    prd_chg    = prd_seen_q && (period_i != period_q);
    auto_req   = (period_i != 32'd0) && !prd_chg && (cnt_q == period_i - 32'd1);
    period_d   = period_i;
    prd_seen_d = 1'b1;
    if (prd_chg || (period_i == 32'd0) || (cnt_q >= period_i - 32'd1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Period counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      period_q   <= '0;
      prd_seen_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      prd_seen_q <= prd_seen_d;
    end
  end

  // Sequencer next state. The DONE cycle doubles as the IDLE decision point for a
  // pending request, which keeps back-to-back refreshes NUM_SCALERS+3 apart.
  always_comb begin
    req          = auto_req | manual_refresh_i;
    state_d      = state_q;
    pend_d       = pend_q;
    latch_pend_d = latch_pend_q;
    idx_d        = idx_q;
    new_data_d   = new_data_q;
    do_latch     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req || pend_q) begin
          state_d = ST_REFRESH;
          pend_d  = 1'b0;
        end
        do_latch = latch_i;
      end
      ST_REFRESH: begin
        state_d = ST_SETTLE;
        if (req)     pend_d       = 1'b1;
        if (latch_i) latch_pend_d = 1'b1;
      end
      ST_SETTLE: begin
        state_d = ST_CAPTURE;
        idx_d   = '0;
        if (req)     pend_d       = 1'b1;
        if (latch_i) latch_pend_d = 1'b1;
      end
      ST_CAPTURE: begin
        if (idx_q == LAST_IDX) begin
          state_d    = ST_DONE;
          new_data_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (req)     pend_d       = 1'b1;
        if (latch_i) latch_pend_d = 1'b1;
      end
      ST_DONE: begin
        do_latch     = latch_i || latch_pend_q;
        latch_pend_d = 1'b0;
        if (req || pend_q) begin
          state_d = ST_REFRESH;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A latch always consumes the "new data" indication, including one in DONE.
    if (do_latch) new_data_d = 1'b0;
    refresh_d = (state_d == ST_REFRESH);
    busy_d    = (state_d != ST_IDLE);
  end

  // Sequencer registers with registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      pend_q       <= 1'b0;
      latch_pend_q <= 1'b0;
      idx_q        <= '0;
      new_data_q   <= 1'b0;
      refresh_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      latch_pend_q <= latch_pend_d;
      idx_q        <= idx_d;
      new_data_q   <= new_data_d;
      refresh_q    <= refresh_d;
      busy_q       <= busy_d;
    end
  end

  // Buffer and read-port next state: one capture word per CAPTURE cycle, whole
  // buffer copy on latch, out-of-range reads return zero.
  always_comb begin
    for (int k = 0; k < NUM_SCALERS; k++) begin
      cap_buf_d[k] = cap_buf_q[k];
      rd_buf_d[k]  = do_latch ? cap_buf_q[k] : rd_buf_q[k];
      if ((state_q == ST_CAPTURE) && (idx_q == IDX_W'(k))) begin
        cap_buf_d[k] = scalers_i[k*WIDTH +: WIDTH];
      end
    end
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = '0;
      for (int k = 0; k < NUM_SCALERS; k++) begin
        if (rd_addr_i == ADDR_W'(k)) rd_data_d = rd_buf_q[k];
      end
    end
  end

  // Buffer and read-port registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_SCALERS; k++) begin
        cap_buf_q[k] <= '0;
        rd_buf_q[k]  <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SCALERS; k++) begin
        cap_buf_q[k] <= cap_buf_d[k];
        rd_buf_q[k]  <= rd_buf_d[k];
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SCALER_READOUT_TIMESTAMP_EN
  logic [31:0] cap_cnt_q, cap_cnt_d;
  logic [31:0] ts_q, ts_d;

  // Capture counter bumps on entry to DONE, so a latch in DONE already sees it.
  always_comb begin
    cap_cnt_d = cap_cnt_q;
    if ((state_q == ST_CAPTURE) && (idx_q == LAST_IDX)) cap_cnt_d = cap_cnt_q + 32'd1;
    ts_d = do_latch ? cap_cnt_q : ts_q;
  end

  // Capture counter and latched snapshot registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap_cnt_q <= '0;
      ts_q      <= '0;
    end else begin
      cap_cnt_q <= cap_cnt_d;
      ts_q      <= ts_d;
    end
  end

  assign refresh_cnt_o = ts_q;
`endif

  assign refresh_o  = refresh_q;
  assign busy_o     = busy_q;
  assign new_data_o = new_data_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_scaler_readout.sv
// Directed bench for scaler_readout with NUM_SCALERS=4: a vector table for the
// manual refresh / latch / read path, then hand-written sequences for refresh
// spacing, deferred latch, auto-refresh timing and reset during capture.
`timescale 1ns/1ps
module tb_scaler_readout;
  localparam int N  = 4;
  localparam int W  = 12;
  localparam int AW = 6;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [31:0]   period_i;
  logic          manual_refresh_i;
  logic [N*W-1:0] scalers_i;
  logic          refresh_o;
  logic          latch_i;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_i;
  logic [W-1:0]  rd_data_o;
  logic          rd_valid_o;
  logic          busy_o;
  logic          new_data_o;
`ifdef SCALER_READOUT_TIMESTAMP_EN
  logic [31:0]   refresh_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  scaler_readout #(.NUM_SCALERS(N), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .period_i         (period_i),
    .manual_refresh_i (manual_refresh_i),
    .scalers_i        (scalers_i),
    .refresh_o        (refresh_o),
    .latch_i          (latch_i),
    .rd_en_i          (rd_en_i),
    .rd_addr_i        (rd_addr_i),
    .rd_data_o        (rd_data_o),
    .rd_valid_o       (rd_valid_o),
    .busy_o           (busy_o),
    .new_data_o       (new_data_o)
`ifdef SCALER_READOUT_TIMESTAMP_EN
    ,.refresh_cnt_o   (refresh_cnt_o)
`endif
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          man;
    logic          lat;
    logic          rd;
    logic [AW-1:0] addr;
    logic          e_ref;
    logic          e_busy;
    logic          e_new;
    logic          e_val;
    logic [W-1:0]  e_data;
  } vec_t;

  vec_t tbl [20];
  int   n_tbl = 0;

  task automatic add_vec(input logic man, input logic lat, input logic rd, input int addr,
                         input logic e_ref, input logic e_busy, input logic e_new,
                         input logic e_val, input int e_data);
    tbl[n_tbl] = '{man: man, lat: lat, rd: rd, addr: AW'(addr), e_ref: e_ref,
                   e_busy: e_busy, e_new: e_new, e_val: e_val, e_data: W'(e_data)};
    n_tbl++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // driver: apply inputs for one clock edge, sample 1ns after it, drop pulses
  task automatic tick(input logic man, input logic lat, input logic rd, input logic [AW-1:0] addr);
    manual_refresh_i = man;
    latch_i          = lat;
    rd_en_i          = rd;
    rd_addr_i        = addr;
    @(posedge clk_i);
    #1;
    manual_refresh_i = 1'b0;
    latch_i          = 1'b0;
    rd_en_i          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < N; k++) scalers_i[k*W +: W] = W'(v);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < N; k++) scalers_i[k*W +: W] = W'(k + 1);
  endtask

  // manual requests on the cycles flagged in mask; expect two pulses 7 apart
  task automatic spacing_run(input string name, input logic [7:0] mask);
    int cnt;
    int first;
    int second;
    cnt = 0; first = -1; second = -1;
    for (int i = 0; i < 40; i++) begin
      tick((i < 8) ? mask[i] : 1'b0, 1'b0, 1'b0, '0);
      if (refresh_o) begin
        cnt++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk({name, "_pulses"}, 0, 32'(cnt), 32'd2);
    chk({name, "_first"}, 0, 32'(first), 32'd0);
    chk({name, "_gap"}, 0, 32'(second - first), 32'd7);
  endtask

  initial begin
    logic [W-1:0] exp_c [4];
    int cnt;
    int p1;
    int p2;
    exp_c = '{12'd5, 12'd5, 12'd9, 12'd9};

    rst_n_i = 1'b0; period_i = 32'd0; manual_refresh_i = 1'b0; latch_i = 1'b0;
    rd_en_i = 1'b0; rd_addr_i = '0;
    set_ramp();

    // reset state
    @(posedge clk_i); #1;
    chk("rst_refresh", 0, 32'(refresh_o), 32'd0);
    chk("rst_busy", 0, 32'(busy_o), 32'd0);
    chk("rst_new", 0, 32'(new_data_o), 32'd0);
    chk("rst_valid", 0, 32'(rd_valid_o), 32'd0);
    chk("rst_data", 0, 32'(rd_data_o), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle(2);

    // table: manual refresh, capture, latch, reads (channels = 1,2,3,4)
    //       man   lat   rd  addr  ref   busy  new   val  data
    add_vec(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0); // REFRESH
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0); // SETTLE
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0); // CAPTURE 0
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0); // CAPTURE 1
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0); // CAPTURE 2
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0); // CAPTURE 3
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0); // DONE
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0); // IDLE
    add_vec(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0); // read before latch
    add_vec(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0); // latch
    add_vec(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add_vec(1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    add_vec(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    add_vec(1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    add_vec(1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b1, 0); // out of range
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);  // data holds
    add_vec(1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4);  // data holds
    for (int i = 0; i < n_tbl; i++) begin
      tick(tbl[i].man, tbl[i].lat, tbl[i].rd, tbl[i].addr);
      chk("tbl_refresh", i, 32'(refresh_o), 32'(tbl[i].e_ref));
      chk("tbl_busy", i, 32'(busy_o), 32'(tbl[i].e_busy));
      chk("tbl_new", i, 32'(new_data_o), 32'(tbl[i].e_new));
      chk("tbl_valid", i, 32'(rd_valid_o), 32'(tbl[i].e_val));
      chk("tbl_data", i, 32'(rd_data_o), 32'(tbl[i].e_data));
    end
    idle(2);

    // refresh spacing and request collapsing (period_i = 0)
    spacing_run("two_reqs", 8'b0000_0101);
    spacing_run("collapse", 8'b0000_1101);
    spacing_run("req_in_done", 8'b1000_0001);

    // latch during CAPTURE with scalers changing 5 -> 9 mid-run
    set_all(5);
    tick(1'b1, 1'b0, 1'b0, '0);
    chk("c_refresh", 0, 32'(refresh_o), 32'd1);
    idle(2);
    tick(1'b0, 1'b1, 1'b0, '0);
    idle(1);
    set_all(9);
    tick(1'b0, 1'b0, 1'b1, 6'd1);
    chk("c_old_data", 0, 32'(rd_data_o), 32'd2);
    chk("c_busy", 0, 32'(busy_o), 32'd1);
    idle(1);
    chk("c_done_new", 0, 32'(new_data_o), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 6'd0);
    chk("c_read_in_done", 0, 32'(rd_data_o), 32'd1);
    chk("c_new_after", 0, 32'(new_data_o), 32'd0);
    chk("c_busy_after", 0, 32'(busy_o), 32'd0);
    for (int k = 0; k < N; k++) begin
      tick(1'b0, 1'b0, 1'b1, AW'(k));
      chk("c_word", k, 32'(rd_data_o), 32'(exp_c[k]));
    end

    // latch coinciding with DONE
    set_all(7);
    tick(1'b1, 1'b0, 1'b0, '0);
    idle(6);
    chk("d_done_new", 0, 32'(new_data_o), 32'd1);
    chk("d_done_busy", 0, 32'(busy_o), 32'd1);
    tick(1'b0, 1'b1, 1'b0, '0);
    chk("d_new_end", 0, 32'(new_data_o), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 6'd0);
    chk("d_word0", 0, 32'(rd_data_o), 32'd7);
    tick(1'b0, 1'b0, 1'b1, 6'd3);
    chk("d_word3", 0, 32'(rd_data_o), 32'd7);

    // auto refresh with period 100 from reset release
    rst_n_i = 1'b0;
    #1;
    chk("r_data", 0, 32'(rd_data_o), 32'd0);
    chk("r_busy", 0, 32'(busy_o), 32'd0);
    period_i = 32'd100;
    set_ramp();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    cnt = 0; p1 = -1; p2 = -1;
    for (int n = 1; n <= 203; n++) begin
      tick(1'b0, n == 110, n == 112, 6'd2);
      if (refresh_o) begin
        cnt++;
        if (p1 < 0) p1 = n;
        else if (p2 < 0) p2 = n;
      end
      if (n == 108) chk("a_new_set", n, 32'(new_data_o), 32'd1);
      if (n == 110) chk("a_new_clr", n, 32'(new_data_o), 32'd0);
      if (n == 112) begin
        chk("a_valid", n, 32'(rd_valid_o), 32'd1);
        chk("a_data", n, 32'(rd_data_o), 32'd3);
      end
    end
    chk("a_pulses", 0, 32'(cnt), 32'd2);
    chk("a_first", 0, 32'(p1), 32'd100);
    chk("a_second", 0, 32'(p2), 32'd200);
    chk("a_busy_capture", 0, 32'(busy_o), 32'd1);

    // reset for one cycle mid-CAPTURE
    rst_n_i = 1'b0;
    #1;
    chk("m_busy", 0, 32'(busy_o), 32'd0);
    chk("m_data", 0, 32'(rd_data_o), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    p1 = -1;
    for (int n = 1; n <= 120; n++) begin
      tick(1'b0, 1'b0, n <= 4, AW'(n - 1));
      if (n <= 4) begin
        chk("m_rd_valid", n, 32'(rd_valid_o), 32'd1);
        chk("m_rd_data", n, 32'(rd_data_o), 32'd0);
      end
      if (refresh_o && p1 < 0) p1 = n;
    end
    chk("m_next_refresh", 0, 32'(p1), 32'd100);

`ifdef SCALER_READOUT_TIMESTAMP_EN
    // three captures then a latch
    rst_n_i = 1'b0;
    period_i = 32'd0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick(1'b1, 1'b0, 1'b0, '0);
      idle(12);
    end
    chk("t_before_latch", 0, refresh_cnt_o, 32'd0);
    tick(1'b0, 1'b1, 1'b0, '0);
    chk("t_count", 0, refresh_cnt_o, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scaler_readout.md
SCALER_READOUT -- requirements
Module: scaler_readout

Interface
REQ-001 Parameter NUM_SCALERS, default 16, is the number of scaler channels in the bank; legal range is 1..64.
REQ-002 Parameter WIDTH, default 12, is the width of each scaler value.
REQ-003 Parameter ADDR_W, default 6, is the read address width; it SHALL satisfy 2^ADDR_W >= NUM_SCALERS.
REQ-004 clk_i  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous and active-low.
REQ-006 period_i  in  32  auto-refresh interval in clk_i cycles; 0 disables auto-refresh.
REQ-007 manual_refresh_i  in  1  one-cycle request for an immediate refresh.
REQ-008 scalers_i  in  NUM_SCALERS*WIDTH  scaler bank outputs; channel k is at [k*WIDTH +: WIDTH].
REQ-009 refresh_o  out  1  one-cycle refresh pulse driven to every scaler in the bank.
REQ-010 latch_i  in  1  host pulse that copies the capture buffer into the read buffer.
REQ-011 rd_en_i, rd_addr_i  in  1, ADDR_W  host read strobe and channel address.
REQ-012 rd_data_o, rd_valid_o  out  WIDTH, 1  read data and its one-cycle qualifier.
REQ-013 busy_o  out  1  high while a refresh/capture sequence is in progress.
REQ-014 new_data_o  out  1  sticky flag: a capture has completed since the last latch.

Function
REQ-015 The period counter SHALL count 0..period_i-1 and raise an auto-request when it reaches period_i-1, then wrap to 0.
REQ-016 When period_i changes, the counter SHALL restart from 0 on the next cycle.
REQ-017 The FSM states SHALL be IDLE -> REFRESH -> SETTLE -> CAPTURE -> DONE -> IDLE.
REQ-018 From IDLE, a pending request (auto or manual) SHALL move the FSM to REFRESH.
REQ-019 In REFRESH, refresh_o SHALL be 1 for exactly one cycle.
REQ-020 SETTLE SHALL last one cycle, because scaler outputs update on the edge after refresh_o.
REQ-021 CAPTURE SHALL copy channel i of scalers_i into capture buffer word i on the i-th CAPTURE cycle, i = 0..NUM_SCALERS-1, taking exactly NUM_SCALERS cycles.
REQ-022 DONE SHALL set new_data_o, last one cycle, and return to IDLE.
REQ-023 The first refresh_o pulse follows its request by 1 cycle; back-to-back sequences SHALL be spaced exactly NUM_SCALERS+3 cycles apart.
REQ-024 Requests that arrive while not in IDLE SHALL be held in a single pending bit; multiple requests collapse into one, and the pending request is serviced on the first IDLE cycle.
REQ-025 busy_o SHALL be 1 in states REFRESH, SETTLE, CAPTURE and DONE.
REQ-026 latch_i in IDLE SHALL copy all NUM_SCALERS capture words into the read buffer in one cycle and clear new_data_o.
REQ-027 latch_i while busy_o=1 SHALL be deferred to the cycle after DONE, so the read buffer never holds words from two different refreshes.
REQ-028 If latch_i coincides with a DONE cycle, the latch SHALL take effect after DONE, and new_data_o SHALL end at 0.
REQ-029 A read (rd_en_i) SHALL return rd_data_o = read buffer[rd_addr_i] with rd_valid_o=1 on the next cycle.
REQ-030 A read with rd_addr_i >= NUM_SCALERS SHALL return 0, with rd_valid_o still asserted.
REQ-031 rd_data_o SHALL hold its value between reads; rd_valid_o SHALL be a single-cycle pulse per rd_en_i.

Reset
REQ-032 rst_n_i=0 SHALL immediately force:
- FSM to IDLE;
- period counter, pending bits and deferred latch to 0;
- refresh_o, busy_o, new_data_o, rd_valid_o and rd_data_o to 0;
- both buffers to all-zero.
REQ-033 Reset asserted during CAPTURE SHALL abort the sequence, and no partial capture SHALL become visible.
REQ-034 The first auto-request after reset release SHALL occur period_i cycles after release.

Configuration
REQ-035 With SCALER_READOUT_TIMESTAMP_EN defined:
- the block SHALL count completed captures in a 32-bit wrapping counter;
- a latch SHALL copy that count to an added output refresh_cnt_o (32 bits);
- refresh_cnt_o is reset to 0.
REQ-036 Without SCALER_READOUT_TIMESTAMP_EN, the block SHALL have no capture counter and no refresh_cnt_o port; all other behaviour is unchanged.

Verification
REQ-037 NUM_SCALERS=4, period_i=100, scalers_i channels={1,2,3,4} -> refresh_o pulses at cycles 100, 200, ...; after each capture new_data_o=1; latch then reads of addr 0..3 -> 1,2,3,4 with a 1-cycle latency.
REQ-038 period_i=0 with manual_refresh_i pulsed twice 2 cycles apart -> exactly two refresh_o pulses, 7 cycles apart (NUM_SCALERS=4).
REQ-039 latch_i during CAPTURE, with scalers_i changing from 5 to 9 mid-run -> the read buffer updates only after DONE, and all words come from that one capture.
REQ-040 Read of rd_addr_i=10 with NUM_SCALERS=4 -> rd_data_o=0 and rd_valid_o=1.
REQ-041 rst_n_i low for 1 cycle mid-CAPTURE -> busy_o=0 and all reads return 0; the next refresh_o arrives period_i cycles after reset release.
REQ-042 With SCALER_READOUT_TIMESTAMP_EN, three captures then a latch -> refresh_cnt_o=3.
